// File: rtl/csr_ctrl_if.sv
// Bundle of every non-clock signal between csr_ctrl, the pipeline and the CSR file.
// csr_ctrl connects as slave; the pipeline/CSR-file side connects as master.
interface csr_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
);
    logic                  csr_valid;
    logic                  csr_ready;
    logic [2:0]            csr_funct3;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [4:0]            rs1_idx;
    logic [XLEN-1:0]       rs1_data;
    logic                  csr_done;
    logic [XLEN-1:0]       rd_data;
    logic                  illegal;
    logic                  trap_req;
    logic [XLEN-1:0]       trap_pc;
    logic [XLEN-1:0]       trap_cause;
    logic                  trap_ack;
    logic                  mret_req;
    logic                  mret_ack;
    logic                  busy;
    logic [CSR_ADDR_W-1:0] f_raddr;
    logic [XLEN-1:0]       f_rdata;
    logic                  f_we;
    logic [CSR_ADDR_W-1:0] f_waddr;
    logic [XLEN-1:0]       f_wdata;
    logic [XLEN-1:0]       mtvec;
    logic [XLEN-1:0]       mepc;
    logic                  pc_redirect;
    logic [XLEN-1:0]       pc_target;

    modport slave (
        input  csr_valid, csr_funct3, csr_addr, rs1_idx, rs1_data,
        input  trap_req, trap_pc, trap_cause, mret_req,
        input  f_rdata, mtvec, mepc,
        output csr_ready, csr_done, rd_data, illegal, trap_ack, mret_ack, busy,
        output f_raddr, f_we, f_waddr, f_wdata, pc_redirect, pc_target
    );

    modport master (
        output csr_valid, csr_funct3, csr_addr, rs1_idx, rs1_data,
        output trap_req, trap_pc, trap_cause, mret_req,
        output f_rdata, mtvec, mepc,
        input  csr_ready, csr_done, rd_data, illegal, trap_ack, mret_ack, busy,
        input  f_raddr, f_we, f_waddr, f_wdata, pc_redirect, pc_target
    );
endinterface

// File: rtl/csr_ctrl.sv
// CSR sequencer: Zicsr read-modify-write, two-write trap entry and mret, owning the
// single CSR-file write port and stalling the pipeline while a sequence runs.
module csr_ctrl #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input logic       clk,
    input logic       rst_n,
    csr_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_TRAP_EPC, S_TRAP_CAUSE, S_TRAP_JUMP, S_MRET_JUMP
    } state_t;

    localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC   = CSR_ADDR_W'(12'h341);
    localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE = CSR_ADDR_W'(12'h342);

    state_t                state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [CSR_ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]            rs1_idx_q, rs1_idx_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       tpc_q, tpc_d;
    logic [XLEN-1:0]       tcause_q, tcause_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;

    logic [XLEN-1:0]       src;
    logic [XLEN-1:0]       rmw_wdata;
    logic                  op_legal;
    logic                  op_writes;

    // funct3[2] selects the zimm form; funct3[1:0] selects RW/RS/RC, 00 is illegal.
    always_comb begin
        src       = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;
        op_legal  = (funct3_q[1:0] != 2'b00);
        op_writes = op_legal && ((funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0));
        case (funct3_q[1:0])
            2'b01:   rmw_wdata = src;
            2'b10:   rmw_wdata = bus.f_rdata | src;
            2'b11:   rmw_wdata = bus.f_rdata & ~src;
            default: rmw_wdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        rs1_idx_d  = rs1_idx_q;
        rs1_data_d = rs1_data_q;
        tpc_d      = tpc_q;
        tcause_d   = tcause_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.trap_req) begin
                    tpc_d    = bus.trap_pc;
                    tcause_d = bus.trap_cause;
                    state_d  = S_TRAP_EPC;
                end else if (bus.mret_req) begin
                    state_d = S_MRET_JUMP;
                end else if (bus.csr_valid) begin
                    funct3_d   = bus.csr_funct3;
                    addr_d     = bus.csr_addr;
                    rs1_idx_d  = bus.rs1_idx;
                    rs1_data_d = bus.rs1_data;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_legal) rd_data_d = bus.f_rdata;
                state_d = S_IDLE;
            end
            S_TRAP_EPC:   state_d = S_TRAP_CAUSE;
            S_TRAP_CAUSE: state_d = S_TRAP_JUMP;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            tpc_q      <= '0;
            tcause_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            rs1_idx_q  <= rs1_idx_d;
            rs1_data_q <= rs1_data_d;
            tpc_q      <= tpc_d;
            tcause_q   <= tcause_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Outputs decode the current state; the CSR file read is combinational, so
    // rd_data and the RMW result are presented in the EXEC cycle itself.
    always_comb begin
        bus.csr_ready   = (state_q == S_IDLE) && !bus.trap_req && !bus.mret_req;
        bus.busy        = (state_q != S_IDLE);
        bus.csr_done    = 1'b0;
        bus.illegal     = 1'b0;
        bus.rd_data     = rd_data_q;
        bus.trap_ack    = 1'b0;
        bus.mret_ack    = 1'b0;
        bus.f_raddr     = '0;
        bus.f_we        = 1'b0;
        bus.f_waddr     = '0;
        bus.f_wdata     = '0;
        bus.pc_redirect = 1'b0;
        bus.pc_target   = '0;
        case (state_q)
            S_EXEC: begin
                bus.f_raddr  = addr_q;
                bus.csr_done = op_legal;
                bus.illegal  = !op_legal;
                if (op_legal) bus.rd_data = bus.f_rdata;
                if (op_writes) begin
                    bus.f_we    = 1'b1;
                    bus.f_waddr = addr_q;
                    bus.f_wdata = rmw_wdata;
                end
            end
            S_TRAP_EPC: begin
                bus.f_we    = 1'b1;
                bus.f_waddr = ADDR_MEPC;
                bus.f_wdata = {tpc_q[XLEN-1:2], 2'b00};
            end
            S_TRAP_CAUSE: begin
                bus.f_we    = 1'b1;
                bus.f_waddr = ADDR_MCAUSE;
                bus.f_wdata = tcause_q;
            end
            S_TRAP_JUMP: begin
                bus.pc_redirect = 1'b1;
                bus.pc_target   = {bus.mtvec[XLEN-1:2], 2'b00};
                bus.trap_ack    = 1'b1;
            end
            S_MRET_JUMP: begin
                bus.pc_redirect = 1'b1;
                bus.pc_target   = {bus.mepc[XLEN-1:2], 2'b00};
                bus.mret_ack    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: table vectors, randomized CSR ops against a
// reference model, and hand-written trap / priority / reset sequences.
module tb_csr_ctrl;
    logic clk;
    logic rst_n;
    int   n_pass = 0;
    int   n_tot  = 0;

    csr_ctrl_if bus ();

    csr_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal CSR-file model for mepc (fed back to the DUT) and an mcause write counter.
    logic [31:0] mepc_r = 32'h0;
    int          mcause_wr = 0;
    always @(posedge clk) begin
        if (bus.f_we && bus.f_waddr == 12'h341) mepc_r <= bus.f_wdata;
        if (bus.f_we && bus.f_waddr == 12'h342) mcause_wr <= mcause_wr + 1;
    end
    assign bus.mepc = mepc_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: Zicsr semantics from the mnemonic table.
    function automatic void ref_csr(input logic [2:0] f3, input logic [4:0] idx,
                                    input logic [31:0] d, input logic [31:0] old,
                                    output logic we, output logic [31:0] wd,
                                    output logic done, output logic ill);
        logic [31:0] s;
        int          op;
        s    = (f3 >= 3'd5) ? 32'(idx) : d;
        op   = int'(f3) % 4;
        ill  = (op == 0);
        done = !ill;
        case (op)
            1:       wd = s;
            2:       wd = old | s;
            3:       wd = old & ~s;
            default: wd = 32'h0;
        endcase
        we = !ill && (op == 1 || idx != 5'd0);
    endfunction

    task automatic do_csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] d, input logic [31:0] old,
                          input logic exp_we, input logic [31:0] exp_wd,
                          input logic exp_done, input logic exp_ill);
        @(posedge clk); #1;
        bus.csr_valid  = 1'b1;
        bus.csr_funct3 = f3;
        bus.csr_addr   = a;
        bus.rs1_idx    = idx;
        bus.rs1_data   = d;
        bus.f_rdata    = old;
        @(negedge clk);
        chk("accept_ready", 32'(bus.csr_ready), 32'd1);
        @(posedge clk); #1;
        bus.rs1_data = ~d;
        bus.rs1_idx  = idx ^ 5'h1f;
        @(negedge clk);
        chk("exec_ready_low", 32'(bus.csr_ready), 32'd0);
        chk("exec_raddr", 32'(bus.f_raddr), 32'(a));
        chk("exec_done", 32'(bus.csr_done), 32'(exp_done));
        chk("exec_illegal", 32'(bus.illegal), 32'(exp_ill));
        chk("exec_we", 32'(bus.f_we), 32'(exp_we));
        if (exp_we) begin
            chk("exec_waddr", 32'(bus.f_waddr), 32'(a));
            chk("exec_wdata", bus.f_wdata, exp_wd);
        end
        if (exp_done) chk("exec_rd_data", bus.rd_data, old);
        bus.csr_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] old;
        logic        we;
        logic [31:0] wdata;
        logic        done;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        we, done, ill;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [4:0]  idx;
        logic [31:0] d, old;
        int          wr_before;

        vecs[0] = '{3'b001, 12'h305, 5'd1, 32'h8000_0100, 32'h0, 1'b1, 32'h8000_0100, 1'b1, 1'b0};
        vecs[1] = '{3'b010, 12'h300, 5'd3, 32'h3, 32'h8, 1'b1, 32'hB, 1'b1, 1'b0};
        vecs[2] = '{3'b010, 12'h300, 5'd0, 32'h3, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{3'b111, 12'h300, 5'd5, 32'hFFFF_FFFF, 32'hF, 1'b1, 32'hA, 1'b1, 1'b0};
        vecs[4] = '{3'b100, 12'h300, 5'd5, 32'h1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[5] = '{3'b000, 12'h340, 5'd2, 32'h1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[6] = '{3'b101, 12'h340, 5'd0, 32'h1234, 32'h77, 1'b1, 32'h0, 1'b1, 1'b0};
        vecs[7] = '{3'b011, 12'h344, 5'd0, 32'hFF, 32'hF0F0, 1'b0, 32'h0, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.csr_valid = 1'b0; bus.csr_funct3 = 3'b0; bus.csr_addr = 12'h0;
        bus.rs1_idx = 5'd0; bus.rs1_data = 32'h0; bus.trap_req = 1'b0;
        bus.trap_pc = 32'h0; bus.trap_cause = 32'h0; bus.mret_req = 1'b0;
        bus.f_rdata = 32'h0; bus.mtvec = 32'h8000_0101;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.csr_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_we", 32'(bus.f_we), 32'd0);
        chk("rst_done", 32'(bus.csr_done), 32'd0);
        chk("rst_redirect", 32'(bus.pc_redirect), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_csr(vecs[i].f3, vecs[i].addr, vecs[i].idx, vecs[i].data, vecs[i].old,
                   vecs[i].we, vecs[i].wdata, vecs[i].done, vecs[i].ill);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d   = $urandom;
            old = $urandom;
            ref_csr(f3, idx, d, old, we, wd, done, ill);
            do_csr(f3, 12'($urandom), idx, d, old, we, wd, done, ill);
        end

        // Trap entry: pc low bits cleared, fields latched at accept, mtvec mode bits cleared.
        @(posedge clk); #1;
        bus.trap_req = 1'b1; bus.trap_pc = 32'h1007; bus.trap_cause = 32'h2;
        @(negedge clk);
        chk("trap_accept_ready", 32'(bus.csr_ready), 32'd0);
        @(posedge clk); #1;
        bus.trap_pc = 32'hDEAD_BEEF; bus.trap_cause = 32'hCAFE;
        @(negedge clk);
        chk("trap_epc_we", 32'(bus.f_we), 32'd1);
        chk("trap_epc_addr", 32'(bus.f_waddr), 32'h341);
        chk("trap_epc_data", bus.f_wdata, 32'h1004);
        chk("trap_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_cause_addr", 32'(bus.f_waddr), 32'h342);
        chk("trap_cause_data", bus.f_wdata, 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_redirect", 32'(bus.pc_redirect), 32'd1);
        chk("trap_target", bus.pc_target, 32'h8000_0100);
        chk("trap_ack", 32'(bus.trap_ack), 32'd1);
        chk("trap_jump_we", 32'(bus.f_we), 32'd0);
        bus.trap_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_done_idle", 32'(bus.busy), 32'd0);
        chk("trap_ack_pulse", 32'(bus.trap_ack), 32'd0);

        // Simultaneous trap, mret and CSR op: served in that order.
        @(posedge clk); #1;
        bus.trap_req = 1'b1; bus.trap_pc = 32'h1004; bus.trap_cause = 32'hB;
        bus.mret_req = 1'b1;
        bus.csr_valid = 1'b1; bus.csr_funct3 = 3'b001; bus.csr_addr = 12'h340;
        bus.rs1_idx = 5'd4; bus.rs1_data = 32'h55; bus.f_rdata = 32'h11;
        @(negedge clk);
        chk("prio_ready", 32'(bus.csr_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_epc_addr", 32'(bus.f_waddr), 32'h341);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_trap_ack", 32'(bus.trap_ack), 32'd1);
        chk("prio_no_mret_ack", 32'(bus.mret_ack), 32'd0);
        bus.trap_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_mret_blocks_csr", 32'(bus.csr_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mret_redirect", 32'(bus.pc_redirect), 32'd1);
        chk("mret_target", bus.pc_target, 32'h1004);
        chk("mret_ack", 32'(bus.mret_ack), 32'd1);
        chk("mret_we", 32'(bus.f_we), 32'd0);
        bus.mret_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_csr_ready", 32'(bus.csr_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_csr_done", 32'(bus.csr_done), 32'd1);
        chk("prio_csr_wdata", bus.f_wdata, 32'h55);
        chk("prio_csr_rd", bus.rd_data, 32'h11);
        bus.csr_valid = 1'b0;

        // Reset during TRAP_CAUSE: outputs clear at once, no mcause write, mepc keeps its write.
        @(posedge clk); #1;
        bus.trap_req = 1'b1; bus.trap_pc = 32'h500; bus.trap_cause = 32'h7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        chk("rst_mid_cause_we", 32'(bus.f_we), 32'd1);
        wr_before = mcause_wr;
        rst_n = 1'b0;
        bus.trap_req = 1'b0;
        #1;
        chk("rst_mid_we", 32'(bus.f_we), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_ready", 32'(bus.csr_ready), 32'd1);
        chk("rst_mid_redirect", 32'(bus.pc_redirect), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", 32'(bus.csr_ready), 32'd1);
        chk("rst_rel_busy", 32'(bus.busy), 32'd0);
        chk("rst_no_mcause", 32'(mcause_wr), 32'(wr_before));
        chk("rst_mepc_kept", mepc_r, 32'h500);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
